mio_bus_master: RTL and testbench
=================================

Name: mio_bus_master

Overview:
- Bus initiator that drives the MIO CPU/peripheral bus from a simple request/response port.
- Turns byte, halfword and word loads/stores into bus cycles:
  - loads: word read, then lane extract and sign/zero extension;
  - sub-word stores to RAM: read-modify-write.
- Sits between the CPU datapath (or a future DMA) and the existing MIO address decoder. Owns the bus signals addr_bus, mem_w, Cpu_data2bus and Cpu_data4bus.

Parameters:
RD_LAT, 1, bus read latency in cycles; address held RD_LAT+1 cycles before Cpu_data4bus is sampled (range 0..7).

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous active-high reset
req  in  1  request valid; sampled only while req_ready=1
req_we  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
req_ready  out  1  high only in IDLE
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  qualifies resp_valid; misaligned, illegal size, or sub-word store outside RAM
resp_rdata  out  32  load result, valid with resp_valid; 0 for stores/errors
addr_bus  out  32  bus address, word-aligned (bits[1:0]=0)
mem_w  out  1  bus write strobe
Cpu_data2bus  out  32  bus write data
Cpu_data4bus  in  32  bus read data

Behaviour:
- Reset: state IDLE. Outputs: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, addr_bus=0, mem_w=0, Cpu_data2bus=0.
- Reset mid-operation aborts the access. If in WRITE, mem_w falls at that edge and no response is issued.
- States: IDLE, READ, WRITE, RESP.
- IDLE: request accepted on an edge with req=1.
  - Captures addr, we, size, unsigned, wdata.
  - Error checks (any hit -> RESP with err=1, no bus activity):
    - size=11;
    - half with addr[0]=1;
    - word with addr[1:0]!=0;
    - sub-word store with addr[31:28]!=4'h0 (peripherals are not read-modify-write safe).
  - Otherwise: word store -> WRITE; anything else -> READ.
- READ: addr_bus={addr[31:2],2'b00}, mem_w=0.
  - Lasts RD_LAT+1 cycles, counted by a 3-bit counter.
  - On the final edge, Cpu_data4bus is latched into an internal word register.
  - Then: load -> RESP; sub-word store -> WRITE.
- WRITE: addr_bus aligned, mem_w=1 for exactly one cycle.
  - Word store: Cpu_data2bus=wdata.
  - Sub-word store: latched word with the target lane replaced. Byte lane = addr[1:0] (little-endian, bits 8*k+7:8*k); half lane = addr[1].
  - -> RESP.
- RESP: resp_valid=1 for one cycle, resp_err as determined.
  - Load resp_rdata: selected lane shifted to bit 0, sign/zero extended per req_unsigned; word loads pass through.
  - -> IDLE.
- addr_bus, mem_w and Cpu_data2bus are 0 in IDLE and RESP.
- Bus outputs are decoded from registered state only (no req-to-bus combinational path).
- Latency from accept edge T (RD_LAT=1), counting the cycle after T as 1:
  - word store: mem_w in cycle 1, resp cycle 2;
  - load: READ cycles 1-2, resp cycle 3;
  - sub-word store: READ 1-2, WRITE 3, resp 4;
  - error: resp cycle 1.
- Back-to-back: req_ready returns to 1 the cycle after RESP. No pipelining; at most one outstanding access.

Decomposition:
- Package mio_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - region constants REG_RAM=4'h0, REG_SEG=4'he, REG_GPIO=4'hf;
  - state enum;
  - RD_LAT max.
- Sub-module mio_lane_unit (combinational): extract/extend for loads and lane merge for stores, from addr[1:0], size and unsigned. Unit-testable on its own.

Test Plan:
1. Word store addr=0x00000010, wdata=0xDEADBEEF -> exactly one mem_w cycle, addr_bus=0x10, Cpu_data2bus=0xDEADBEEF; resp_valid 2 cycles after accept, err=0.
2. Signed byte load addr=0x00000013, bus returns 0x80FF1234 -> resp_rdata=0xFFFFFF80. Same with req_unsigned=1 -> 0x00000080. Address held RD_LAT+1 cycles, mem_w never 1.
3. Byte store addr=0x00000021, wdata=0x000000AB, RAM word 0x11223344 -> read, then one write of 0x1122AB44 to 0x20; resp 4 cycles after accept.
4. Errors, each -> resp_err=1 one cycle after accept, mem_w=0 throughout:
   - half load at 0x00000003;
   - size=11;
   - byte store at 0xF0000000.
5. Half load from 0xE0000002 with Cpu_data4bus=0x7FFF0001, RD_LAT=3 -> address held 4 cycles, resp_rdata=0x00007FFF.
6. rst asserted during READ of a sub-word store -> no mem_w pulse, no resp_valid; IDLE and req_ready=1 after release; next request completes normally.

Source files
------------

// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus master.
//   - access size encodings carried on req_size
//   - address region codes (addr[31:28])
//   - master FSM state type
//   - upper bound for the RD_LAT parameter
package mio_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] REG_RAM  = 4'h0;
  localparam logic [3:0] REG_SEG  = 4'he;
  localparam logic [3:0] REG_GPIO = 4'hf;

  localparam int RD_LAT_MAX = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mio_lane_unit.sv
// Combinational byte-lane unit for the MIO bus master.
// Ports:
//   addr_lo     in  byte offset within the word (little-endian lanes)
//   size        in  access size (SZ_BYTE/SZ_HALF/SZ_WORD)
//   unsigned_ld in  1 = zero-extend loads, 0 = sign-extend
//   rword       in  full word read from the bus
//   wdata       in  right-aligned store data
//   rdata       out load result: lane shifted to bit 0 and extended
//   mdata       out rword with the addressed lane replaced by wdata
module mio_lane_unit
  import mio_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] mdata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rword[8*addr_lo +: 8];
    lane_h = addr_lo[1] ? rword[31:16] : rword[15:0];
    rdata  = rword;
    mdata  = rword;
    case (size)
      SZ_BYTE: begin
        rdata = unsigned_ld ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
        mdata[8*addr_lo +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        rdata = unsigned_ld ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
        if (addr_lo[1]) mdata[31:16] = wdata[15:0];
        else            mdata[15:0]  = wdata[15:0];
      end
      default: begin
        rdata = rword;
        mdata = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mio_bus_master.sv
// MIO bus initiator: converts single load/store requests into MIO bus
// cycles (word read, word write, or read-modify-write for sub-word stores).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req, req_we, req_size,   request handshake and attributes,
//   req_unsigned, req_addr,  accepted only while req_ready=1
//   req_wdata
//   req_ready                high in IDLE
//   resp_valid, resp_err,    one-cycle completion pulse with status
//   resp_rdata               and load data (0 for stores/errors)
//   addr_bus, mem_w,         bus outputs, decoded from registered state
//   Cpu_data2bus
//   Cpu_data4bus             bus read data, sampled on the last READ edge
module mio_bus_master
  import mio_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] addr_bus,
  output logic        mem_w,
  output logic [31:0] Cpu_data2bus,
  input  logic [31:0] Cpu_data4bus
);

  state_t      state;
  logic [2:0]  cnt;
  logic        err_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] lane_rdata;
  logic [31:0] lane_mdata;

  // Peripherals outside RAM must not see a read-modify-write, so sub-word
  // stores there are rejected along with size/alignment errors.
  function automatic logic req_bad(input logic [1:0] sz, input logic [31:0] a,
                                   input logic we);
    logic bad;
    bad = 1'b0;
    if (sz == 2'b11) bad = 1'b1;
    if (sz == SZ_HALF && a[0]) bad = 1'b1;
    if (sz == SZ_WORD && a[1:0] != 2'b00) bad = 1'b1;
    if (we && sz != SZ_WORD && a[31:28] != REG_RAM) bad = 1'b1;
    return bad;
  endfunction

  // Control: FSM, read-latency counter, error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 3'd0;
      err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= 3'd0;
          if (req) begin
            err_q <= req_bad(req_size, req_addr, req_we);
            if (req_bad(req_size, req_addr, req_we))  state <= ST_RESP;
            else if (req_we && req_size == SZ_WORD)   state <= ST_WRITE;
            else                                      state <= ST_READ;
          end
        end
        ST_READ: begin
          if (cnt == 3'(RD_LAT)) state <= we_q ? ST_WRITE : ST_RESP;
          else                   cnt   <= cnt + 3'd1;
        end
        ST_WRITE: state <= ST_RESP;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Data: request capture and read-word latch (no reset needed)
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && req) begin
      addr_q  <= req_addr;
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      wdata_q <= req_wdata;
    end
    if (state == ST_READ && cnt == 3'(RD_LAT)) word_q <= Cpu_data4bus;
  end

  mio_lane_unit u_lane (
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .unsigned_ld (uns_q),
    .rword       (word_q),
    .wdata       (wdata_q),
    .rdata       (lane_rdata),
    .mdata       (lane_mdata)
  );

  // Outputs decoded from registered state only
  always_comb begin
    req_ready    = (state == ST_IDLE);
    resp_valid   = (state == ST_RESP);
    resp_err     = (state == ST_RESP) && err_q;
    resp_rdata   = (state == ST_RESP && !err_q && !we_q) ? lane_rdata : 32'h0;
    addr_bus     = (state == ST_READ || state == ST_WRITE) ?
                   {addr_q[31:2], 2'b00} : 32'h0;
    mem_w        = (state == ST_WRITE);
    Cpu_data2bus = (state == ST_WRITE) ? lane_mdata : 32'h0;
  end

endmodule

// File: tb/tb_mio_bus_master.sv
module tb_mio_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        sel3 = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] bus_rd = 32'h0;

  logic        rdy1, rv1, re1, mw1, rdy3, rv3, re3, mw3;
  logic [31:0] rd1, ab1, d2b1, rd3, ab3, d2b3;
  logic        req1, req3;

  assign req1 = req & ~sel3;
  assign req3 = req & sel3;

  always #5 clk = ~clk;

  mio_bus_master #(.RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .req(req1), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(rdy1), .resp_valid(rv1), .resp_err(re1), .resp_rdata(rd1),
    .addr_bus(ab1), .mem_w(mw1), .Cpu_data2bus(d2b1), .Cpu_data4bus(bus_rd)
  );

  mio_bus_master #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(rdy3), .resp_valid(rv3), .resp_err(re3), .resp_rdata(rd3),
    .addr_bus(ab3), .mem_w(mw3), .Cpu_data2bus(d2b3), .Cpu_data4bus(bus_rd)
  );

  logic        m_rdy, m_rv, m_re, m_mw;
  logic [31:0] m_rd, m_ab, m_d2b;
  assign m_rdy = sel3 ? rdy3 : rdy1;
  assign m_rv  = sel3 ? rv3  : rv1;
  assign m_re  = sel3 ? re3  : re1;
  assign m_mw  = sel3 ? mw3  : mw1;
  assign m_rd  = sel3 ? rd3  : rd1;
  assign m_ab  = sel3 ? ab3  : ab1;
  assign m_d2b = sel3 ? d2b3 : d2b1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // results of the last transaction
  int          t_rc, t_wcnt, t_rdcyc;
  logic        t_err;
  logic [31:0] t_rdata, t_waddr, t_wdat, t_raddr;

  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd);
    bit done;
    @(negedge clk);
    req = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req = 1'b0;
    t_rc = 0; t_wcnt = 0; t_rdcyc = 0; t_err = 1'b0;
    t_rdata = 32'h0; t_waddr = 32'h0; t_wdat = 32'h0; t_raddr = 32'h0;
    done = 1'b0;
    for (int k = 1; k <= 24 && !done; k++) begin
      @(negedge clk);
      if (m_mw) begin
        t_wcnt++; t_waddr = m_ab; t_wdat = m_d2b;
      end else if (m_ab != 32'h0) begin
        t_rdcyc++; t_raddr = m_ab;
      end
      if (m_rv) begin
        done = 1'b1; t_rc = k; t_err = m_re; t_rdata = m_rd;
      end
    end
    if (!done) chk("resp_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("idle_ready", {31'h0, m_rdy}, 32'd1);
    chk("idle_bus", m_ab | m_d2b | {31'h0, m_mw}, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, rdy1}, 32'd1);
    chk("rst_valid", {30'h0, rv1, re1}, 32'd0);
    chk("rst_rdata", rd1, 32'h0);
    chk("rst_bus", ab1 | d2b1 | {31'h0, mw1}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // word store
    txn(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    chk("ws_rc", t_rc, 2);
    chk("ws_err", {31'h0, t_err}, 0);
    chk("ws_wcnt", t_wcnt, 1);
    chk("ws_waddr", t_waddr, 32'h10);
    chk("ws_wdata", t_wdat, 32'hDEAD_BEEF);
    chk("ws_rdcyc", t_rdcyc, 0);
    chk("ws_rdata", t_rdata, 32'h0);

    // signed / unsigned byte load
    bus_rd = 32'h80FF_1234;
    txn(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0);
    chk("lbs_rdata", t_rdata, 32'hFFFF_FF80);
    chk("lbs_rc", t_rc, 3);
    chk("lbs_rdcyc", t_rdcyc, 2);
    chk("lbs_raddr", t_raddr, 32'h10);
    chk("lbs_wcnt", t_wcnt, 0);
    txn(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0);
    chk("lbu_rdata", t_rdata, 32'h0000_0080);
    chk("lbu_wcnt", t_wcnt, 0);

    // signed half load, upper lane negative
    bus_rd = 32'h8001_5555;
    txn(1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0);
    chk("lhs_rdata", t_rdata, 32'hFFFF_8001);
    // word load
    bus_rd = 32'hCAFE_F00D;
    txn(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0);
    chk("lw_rdata", t_rdata, 32'hCAFE_F00D);
    chk("lw_raddr", t_raddr, 32'h8);

    // byte store read-modify-write
    bus_rd = 32'h1122_3344;
    txn(1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'h0000_00AB);
    chk("sb_rdcyc", t_rdcyc, 2);
    chk("sb_wcnt", t_wcnt, 1);
    chk("sb_waddr", t_waddr, 32'h20);
    chk("sb_wdata", t_wdat, 32'h1122_AB44);
    chk("sb_rc", t_rc, 4);
    chk("sb_rdata", t_rdata, 32'h0);
    // half store upper lane
    txn(1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h1234_BEEF);
    chk("sh_wdata", t_wdat, 32'hBEEF_3344);

    // errors
    txn(1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0);
    chk("e_half_err", {31'h0, t_err}, 1);
    chk("e_half_rc", t_rc, 1);
    chk("e_half_bus", t_wcnt + t_rdcyc, 0);
    txn(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0);
    chk("e_size_err", {31'h0, t_err}, 1);
    chk("e_size_rc", t_rc, 1);
    txn(1'b1, 2'b00, 1'b0, 32'hF000_0000, 32'h55);
    chk("e_perw_err", {31'h0, t_err}, 1);
    chk("e_perw_rc", t_rc, 1);
    chk("e_perw_wcnt", t_wcnt, 0);
    txn(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
    chk("e_word_err", {31'h0, t_err}, 1);

    // RD_LAT=3 half load from segment region
    sel3 = 1'b1;
    bus_rd = 32'h7FFF_0001;
    txn(1'b0, 2'b01, 1'b0, 32'hE000_0002, 32'h0);
    chk("l3_rdcyc", t_rdcyc, 4);
    chk("l3_raddr", t_raddr, 32'hE000_0000);
    chk("l3_rdata", t_rdata, 32'h0000_7FFF);
    chk("l3_rc", t_rc, 5);
    chk("l3_wcnt", t_wcnt, 0);
    sel3 = 1'b0;

    // reset during READ of a sub-word store
    begin
      int seen_w, seen_v;
      seen_w = 0; seen_v = 0;
      @(negedge clk);
      req = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h0000_0021; req_wdata = 32'hAB;
      @(posedge clk);
      #1 req = 1'b0;
      @(negedge clk);
      chk("rr_reading", ab1, 32'h20);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rr_ready", {31'h0, rdy1}, 1);
      for (int k = 0; k < 5; k++) begin
        if (mw1) seen_w++;
        if (rv1) seen_v++;
        @(negedge clk);
      end
      chk("rr_no_memw", seen_w, 0);
      chk("rr_no_resp", seen_v, 0);
    end
    txn(1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h0BAD_F00D);
    chk("rr_next_rc", t_rc, 2);
    chk("rr_next_wdata", t_wdat, 32'h0BAD_F00D);
    chk("rr_next_waddr", t_waddr, 32'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
